// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
// Header/target byte codes, RX and loader state enums, baud divider helper.
package uart_prog_loader_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] TGT_INSTR = 8'h00;
  localparam logic [7:0] TGT_DATA  = 8'h01;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [3:0] {
    L_IDLE,
    L_HDR,
    L_TGT,
    L_CNT_LO,
    L_CNT_HI,
    L_WORD,
    L_WRITE,
    L_DONE,
    L_ERROR
  } ld_state_t;

  // Clocks per 16x oversampling tick; never below one.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver with 16x oversampling: 2-flop synchronizer, tick generator,
// start-bit glitch rejection, one-cycle byte_valid / frame_err pulses.
module uart_prog_loader_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_FREQ = 23000000,
  parameter int BAUD     = 128000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             rx_p0, rx_p1, rx_p2;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  rx_state_t        state, state_nxt;
  logic [3:0]       sub_cnt, sub_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             vld_nxt, ferr_nxt;

  assign tick    = (tick_cnt == DIV_LAST);
  assign rx_byte = shift;

  // Synchronizer stages preset high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      tick_cnt   <= '0;
      state      <= R_IDLE;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      state      <= state_nxt;
      sub_cnt    <= sub_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      byte_valid <= vld_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sub_cnt_nxt = sub_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    vld_nxt     = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      R_IDLE: begin
        sub_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (rx_p2 && !rx_p1) state_nxt = R_START;
      end
      R_START: if (tick) begin
        sub_cnt_nxt = sub_cnt + 4'd1;
        if (sub_cnt == 4'd7) begin
          sub_cnt_nxt = '0;
          state_nxt   = rx_p1 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: if (tick) begin
        sub_cnt_nxt = sub_cnt + 4'd1;
        if (sub_cnt == 4'd15) begin
          shift_nxt   = {rx_p1, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = R_STOP;
        end
      end
      R_STOP: if (tick) begin
        sub_cnt_nxt = sub_cnt + 4'd1;
        if (sub_cnt == 4'd15) begin
          vld_nxt   = rx_p1;
          ferr_nxt  = !rx_p1;
          state_nxt = R_IDLE;
        end
      end
      default: state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses A5 / target / count / words frames and writes
// 32-bit words to instruction or data memory while holding the CPU in reset.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 23000000,
  parameter int BAUD       = 128000,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  start_load,
  output logic                  load_active,
  output logic                  mem_we,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  error
);

  logic [7:0]  rx_byte;
  logic        byte_valid, frame_err;

  ld_state_t             state, state_nxt;
  logic                  sel_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [31:0]           wdata_nxt;
  logic [1:0]            byte_idx, byte_idx_nxt;
  logic [15:0]           word_cnt, word_cnt_nxt;
  logic [15:0]           word_total, word_total_nxt;
  logic [7:0]            cnt_lo, cnt_lo_nxt;
  logic [15:0]           n_rx;

  uart_prog_loader_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clock      (clock),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign n_rx        = {rx_byte, cnt_lo};
  assign mem_we      = (state == L_WRITE);
  assign done        = (state == L_DONE);
  assign error       = (state == L_ERROR);
  assign load_active = state inside {L_HDR, L_TGT, L_CNT_LO, L_CNT_HI, L_WORD, L_WRITE};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= L_IDLE;
      mem_sel    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      cnt_lo     <= '0;
    end else begin
      state      <= state_nxt;
      mem_sel    <= sel_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      byte_idx   <= byte_idx_nxt;
      word_cnt   <= word_cnt_nxt;
      word_total <= word_total_nxt;
      cnt_lo     <= cnt_lo_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = mem_sel;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    byte_idx_nxt   = byte_idx;
    word_cnt_nxt   = word_cnt;
    word_total_nxt = word_total;
    cnt_lo_nxt     = cnt_lo;
    // A new start wins over any byte or framing event in the same cycle.
    if (start_load) begin
      state_nxt    = L_HDR;
      addr_nxt     = '0;
      wdata_nxt    = '0;
      byte_idx_nxt = '0;
      word_cnt_nxt = '0;
    end else if (frame_err && (state inside {L_HDR, L_TGT, L_CNT_LO, L_CNT_HI, L_WORD})) begin
      state_nxt = L_ERROR;
    end else begin
      case (state)
        L_HDR: if (byte_valid && rx_byte == HDR_BYTE) state_nxt = L_TGT;
        L_TGT: if (byte_valid) begin
          if (rx_byte == TGT_INSTR || rx_byte == TGT_DATA) begin
            sel_nxt   = rx_byte[0];
            state_nxt = L_CNT_LO;
          end else begin
            state_nxt = L_ERROR;
          end
        end
        L_CNT_LO: if (byte_valid) begin
          cnt_lo_nxt = rx_byte;
          state_nxt  = L_CNT_HI;
        end
        L_CNT_HI: if (byte_valid) begin
          word_total_nxt = n_rx;
          if (n_rx == 16'd0)                                  state_nxt = L_DONE;
          else if (32'(n_rx) > (32'd1 << ADDR_WIDTH))        state_nxt = L_ERROR;
          else                                                state_nxt = L_WORD;
        end
        L_WORD: if (byte_valid) begin
          wdata_nxt[{byte_idx, 3'b000} +: 8] = rx_byte;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nxt = L_WRITE;
        end
        // Address advances after the strobe cycle; it wraps at 2^ADDR_WIDTH.
        L_WRITE: begin
          addr_nxt     = mem_addr + ADDR_WIDTH'(1);
          word_cnt_nxt = word_cnt + 16'd1;
          state_nxt    = (word_cnt + 16'd1 == word_total) ? L_DONE : L_WORD;
        end
        default: state_nxt = state;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: drives 8N1 frames at 16 clocks per bit
// and checks memory writes and status against hand-computed values.
module tb_uart_prog_loader;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          start_load;
  logic          load_active, mem_we, mem_sel, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] frame[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         we_double    = 0;
  logic       we_prev      = 1'b0;

  uart_prog_loader #(
    .CLK_FREQ   (1600000),
    .BAUD       (100000),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .rx          (rx),
    .start_load  (start_load),
    .load_active (load_active),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we) wq.push_back('{sel: mem_sel, addr: mem_addr, data: mem_wdata});
    if (mem_we && we_prev) we_double++;
    we_prev = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(negedge clock);
    start_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(16);
    end
    rx = stop_bit;
    idle(16);
    rx = 1'b1;
    idle(2);
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i], 1'b1);
    idle(20);
  endtask

  task automatic check_wr(input string tag, input int i, input logic sel,
                          input logic [AW-1:0] addr, input logic [31:0] data);
    check({tag, "_present"}, 32'(wq.size() > i), 32'd1);
    if (wq.size() > i) begin
      check({tag, "_sel"},  32'(wq[i].sel),  32'(sel));
      check({tag, "_addr"}, 32'(wq[i].addr), 32'(addr));
      check({tag, "_data"}, wq[i].data,      data);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rx         = 1'b1;
    start_load = 1'b0;
    idle(3);
    check("rst_load_active", 32'(load_active), 32'd0);
    check("rst_mem_we",      32'(mem_we),      32'd0);
    check("rst_mem_sel",     32'(mem_sel),     32'd0);
    check("rst_mem_addr",    32'(mem_addr),    32'd0);
    check("rst_mem_wdata",   mem_wdata,        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_error",       32'(error),       32'd0);
    rst_n = 1'b1;
    idle(50);
    check("idle_no_writes", 32'(wq.size()), 32'd0);
    check("idle_inactive",  32'(load_active), 32'd0);

    // Two instruction words
    pulse_start();
    check("f1_active", 32'(load_active), 32'd1);
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    check("f1_nwr", 32'(wq.size()), 32'd2);
    check_wr("f1_w0", 0, 1'b0, 14'd0, 32'h12345678);
    check_wr("f1_w1", 1, 1'b0, 14'd1, 32'hDEADBEEF);
    check("f1_done",     32'(done),        32'd1);
    check("f1_inactive", 32'(load_active), 32'd0);
    check("f1_addr",     32'(mem_addr),    32'd2);

    // Leading junk byte, one data-memory word
    wq.delete();
    pulse_start();
    check("f2_done_clr", 32'(done), 32'd0);
    frame = '{8'h33, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    send_frame();
    check("f2_nwr", 32'(wq.size()), 32'd1);
    check_wr("f2_w0", 0, 1'b1, 14'd0, 32'h01020304);
    check("f2_done", 32'(done), 32'd1);

    // Bad target code
    wq.delete();
    pulse_start();
    frame = '{8'hA5, 8'h07};
    send_frame();
    check("tgt_error",    32'(error),       32'd1);
    check("tgt_inactive", 32'(load_active), 32'd0);
    check("tgt_nwr",      32'(wq.size()),   32'd0);
    pulse_start();
    check("tgt_err_clr",  32'(error),       32'd0);
    check("tgt_rearm",    32'(load_active), 32'd1);

    // Framing error inside a word
    pulse_start();
    frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11};
    foreach (frame[i]) send_byte(frame[i], 1'b1);
    send_byte(8'h22, 1'b0);
    idle(20);
    check("ferr_error", 32'(error),     32'd1);
    check("ferr_nwr",   32'(wq.size()), 32'd0);

    // Count larger than the address space
    pulse_start();
    frame = '{8'hA5, 8'h00, 8'h01, 8'h40};
    send_frame();
    check("big_n_error", 32'(error), 32'd1);

    // Zero-word load finishes immediately
    pulse_start();
    frame = '{8'hA5, 8'h01, 8'h00, 8'h00};
    send_frame();
    check("zero_n_done", 32'(done),       32'd1);
    check("zero_n_nwr",  32'(wq.size()),  32'd0);

    // Short low glitch while waiting for the header is rejected
    pulse_start();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    check("glitch_active", 32'(load_active), 32'd1);
    check("glitch_error",  32'(error),       32'd0);
    frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame();
    check_wr("glitch_w0", 0, 1'b0, 14'd0, 32'hDDCCBBAA);
    check("glitch_done", 32'(done), 32'd1);

    // Reset in the middle of the second word
    wq.delete();
    pulse_start();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (frame[i]) send_byte(frame[i], 1'b1);
    idle(4);
    check("mid_addr", 32'(mem_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_active", 32'(load_active), 32'd0);
    check("arst_addr",   32'(mem_addr),    32'd0);
    check("arst_wdata",  mem_wdata,        32'd0);
    check("arst_we",     32'(mem_we),      32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    wq.delete();
    pulse_start();
    frame = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_frame();
    check("rs_nwr", 32'(wq.size()), 32'd1);
    check_wr("rs_w0", 0, 1'b1, 14'd0, 32'h11223344);
    check("rs_done", 32'(done), 32'd1);

    check("we_single_cycle", 32'(we_double), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
